fp_add_align_stage: RTL and testbench
=====================================

// Module: fp_add_align_stage
// PURPOSE
//  First stage of the parametrised multi-cycle FP add/sub pipeline. Per lane: compare magnitudes,
//  swap so operand A is the larger, compute a saturated alignment shift, and classify specials
//  (NaN/Inf/zero). Registered, with a valid/ready handshake and per-thread rollback squash.
//  Sits between operand fetch and the align/add stage; supersedes the fixed FP32, no-stall stage 1.
// PARAMETERS
//  LANES      16   vector lanes processed in parallel
//  EXP_WIDTH  8    exponent bits (8 = binary32, 5 = binary16)
//  SIG_WIDTH  23   stored significand bits, hidden bit excluded
//  TID_WIDTH  2    thread index width
//  SHIFT_W    $clog2(SIG_WIDTH+4)  alignment shift width (derived, not overridden)
// PORTS
//  clk                 in   1                     clock
//  reset               in   1                     async active-high reset
//  rollback_en         in   1                     squash all work for rollback_tid
//  rollback_tid        in   TID_WIDTH             thread being rolled back
//  in_valid            in   1                     input beat valid
//  in_ready            out  1                     stage can accept a beat this cycle
//  in_tid              in   TID_WIDTH             thread of input beat
//  in_subtract         in   1                     1 = A-B, 0 = A+B
//  in_mask             in   LANES                 lane enable mask (passed through)
//  in_op_a / in_op_b   in   LANES*(1+EXP_WIDTH+SIG_WIDTH)  packed IEEE operands
//  out_valid           out  1                     output beat valid
//  out_ready           in   1                     downstream accepts beat
//  out_tid / out_mask  out  TID_WIDTH / LANES     passed through
//  out_sig_large       out  LANES*(SIG_WIDTH+1)   significand of larger-magnitude op, hidden bit incl.
//  out_sig_small       out  LANES*(SIG_WIDTH+1)   significand of smaller op, unshifted
//  out_shift           out  LANES*SHIFT_W         exponent difference, saturated
//  out_exponent        out  LANES*EXP_WIDTH       exponent of larger op
//  out_logical_sub     out  LANES                 sign_a ^ sign_b ^ in_subtract
//  out_result_sign     out  LANES                 sign of result (see rules)
//  out_special         out  LANES*2               00 normal, 01 zero result, 10 Inf, 11 NaN
// BEHAVIOUR
//  - Reset: out_valid=0; all datapath outputs 0. in_ready=1 out of reset.
//  - Latency 1 cycle. Single output register; in_ready = !out_valid || out_ready (combinational).
//  - Load when in_valid && in_ready. Output held stable while out_valid && !out_ready.
//  - Rollback: incoming beat with in_tid==rollback_tid is not loaded (out_valid<=0 if reg freed);
//    held beat with out_tid==rollback_tid drops out_valid next cycle, even if out_ready=0.
//    Rollback and unrelated in beat in same cycle: held beat dropped, new beat loads.
//  - Hidden bit = (exp != 0). Swap when {exp_b,sig_b} > {exp_a,sig_a}; ties do not swap.
//  - shift = exp_large - exp_small, saturated at SIG_WIDTH+3 (guard+round+sticky fully shifted).
//  - result_sign: larger op sign; B sign inverted when in_subtract before compare.
//    Exact cancellation (equal magnitude, logical_sub) -> sign 0, special=01.
//  - Specials priority: any NaN, or Inf-Inf with logical_sub -> 11 (sign 0);
//    one/both Inf (same effective sign) -> 10 with Inf's sign; both zero -> 01, sign = sign_a & sign_b_eff.
//  - Masked-off lanes still compute; mask is only forwarded.
//  - Reset asserted mid-operation discards held beat immediately.
// CONFIGURATION
//  FP_ADD_DENORM_FLUSH_EN defined: subnormal inputs (exp==0, sig!=0) treated as signed zero
//   before compare; special=01 if both flushed. Undefined: subnormals kept, hidden bit 0,
//   effective exponent 1 used for shift (shift = exp_large - max(exp_small,1)).
// STRUCTURE
//  - Shared package: fp_special_t enum (FP_NORMAL, FP_ZERO, FP_INF, FP_NAN), thread_idx_t,
//    parametrised fp_operand struct helpers.
//  - Sub-module fp_add_align_lane: combinational per-lane swap/shift/classify, instantiated LANES
//    times in generate; top holds handshake, rollback and output register.
// TESTING
//  - FP32, a=3.0 (0x40400000), b=1.0, add -> large sig 0xC00000, small 0x800000, shift 1, exp 128.
//  - a=1.0, b=-2.0, add -> swapped, exponent 128, logical_sub=1, result_sign=1.
//  - a=0x7F000000, b=0x00800000 -> shift saturates at 26, not 253.
//  - a=+Inf, b=+Inf, subtract -> special=11; a=NaN, b=1.0 -> 11; a=1.0,b=1.0 sub -> 01, sign 0.
//  - out_ready=0 for 3 cycles with new in_valid -> in_ready=0, outputs stable; then rollback on
//    held tid -> out_valid=0 next cycle, in_ready=1.
//  - Subnormal b=0x00000001, a=1.0: with FLUSH_EN -> special 00, small sig 0; without -> sig 1, shift 26.

Source files
------------

// File: rtl/fp_add_align_stage_pkg.sv
// rtl/fp_add_align_stage_pkg.sv - shared types and classify helpers for the FP add align stage
package fp_add_align_stage_pkg;

  typedef enum logic [1:0] {
    FP_NORMAL = 2'b00,
    FP_ZERO   = 2'b01,
    FP_INF    = 2'b10,
    FP_NAN    = 2'b11
  } fp_special_t;

  localparam int DEFAULT_TID_WIDTH = 2;
  typedef logic [DEFAULT_TID_WIDTH-1:0] thread_idx_t;

  typedef struct packed {
    logic nan;
    logic inf;
    logic zero;
  } fp_class_t;

  // Width-independent: callers reduce exponent/mantissa to these three flags first.
  function automatic fp_class_t fp_classify(input logic exp_all_ones, input logic exp_zero,
                                            input logic man_zero);
    fp_class_t c;
    c.nan  = exp_all_ones & ~man_zero;
    c.inf  = exp_all_ones & man_zero;
    c.zero = exp_zero & man_zero;
    return c;
  endfunction

  function automatic fp_special_t fp_resolve_special(input fp_class_t a, input fp_class_t b,
                                                     input logic logical_sub,
                                                     input logic equal_mag);
    if (a.nan || b.nan || (a.inf && b.inf && logical_sub))
      return FP_NAN;
    else if (a.inf || b.inf)
      return FP_INF;
    else if ((a.zero && b.zero) || (equal_mag && logical_sub))
      return FP_ZERO;
    else
      return FP_NORMAL;
  endfunction

endpackage

// File: rtl/fp_add_align_lane.sv
// rtl/fp_add_align_lane.sv - per-lane magnitude swap, saturated align shift and special classify
// Optional: FP_ADD_DENORM_FLUSH_EN flushes subnormal inputs to signed zero.
module fp_add_align_lane
  import fp_add_align_stage_pkg::*;
#(
  parameter  int EXP_WIDTH = 8,
  parameter  int SIG_WIDTH = 23,
  localparam int SHIFT_W   = $clog2(SIG_WIDTH + 4),
  localparam int OP_W      = 1 + EXP_WIDTH + SIG_WIDTH
) (
  input  logic [OP_W-1:0]      op_a,
  input  logic [OP_W-1:0]      op_b,
  input  logic                 subtract,
  output logic [SIG_WIDTH:0]   sig_large,
  output logic [SIG_WIDTH:0]   sig_small,
  output logic [SHIFT_W-1:0]   shift,
  output logic [EXP_WIDTH-1:0] exponent,
  output logic                 logical_sub,
  output logic                 result_sign,
  output fp_special_t          special
);

  localparam logic [EXP_WIDTH:0] MAX_SHIFT = (EXP_WIDTH + 1)'(SIG_WIDTH + 3);

  logic                 sign_a, sign_b_eff;
  logic [EXP_WIDTH-1:0] exp_a, exp_b;
  logic [SIG_WIDTH-1:0] man_a, man_b;

  assign sign_a     = op_a[OP_W-1];
  assign sign_b_eff = op_b[OP_W-1] ^ subtract;
  assign exp_a      = op_a[OP_W-2 -: EXP_WIDTH];
  assign exp_b      = op_b[OP_W-2 -: EXP_WIDTH];

`ifdef FP_ADD_DENORM_FLUSH_EN
  assign man_a = (exp_a == '0) ? '0 : op_a[SIG_WIDTH-1:0];
  assign man_b = (exp_b == '0) ? '0 : op_b[SIG_WIDTH-1:0];
`else
  assign man_a = op_a[SIG_WIDTH-1:0];
  assign man_b = op_b[SIG_WIDTH-1:0];
`endif

  fp_class_t            cls_a, cls_b;
  logic                 swap, equal_mag;
  logic [EXP_WIDTH-1:0] exp_large, exp_small, exp_small_eff;
  logic [SIG_WIDTH-1:0] man_large, man_small;
  logic [EXP_WIDTH:0]   diff;

  assign cls_a = fp_classify(&exp_a, ~|exp_a, ~|man_a);
  assign cls_b = fp_classify(&exp_b, ~|exp_b, ~|man_b);

  always_comb begin
    swap      = {exp_b, man_b} > {exp_a, man_a};
    equal_mag = {exp_b, man_b} == {exp_a, man_a};
    exp_large = swap ? exp_b : exp_a;
    exp_small = swap ? exp_a : exp_b;
    man_large = swap ? man_b : man_a;
    man_small = swap ? man_a : man_b;
    sig_large = {|exp_large, man_large};
    sig_small = {|exp_small, man_small};
    exponent  = exp_large;

`ifdef FP_ADD_DENORM_FLUSH_EN
    exp_small_eff = exp_small;
`else
    // Subnormals share the scale of exponent 1.
    exp_small_eff = (exp_small == '0) ? EXP_WIDTH'(1) : exp_small;
`endif

    diff = {1'b0, exp_large} - {1'b0, exp_small_eff};
    if (diff[EXP_WIDTH])
      shift = '0;
    else if (diff > MAX_SHIFT)
      shift = MAX_SHIFT[SHIFT_W-1:0];
    else
      shift = diff[SHIFT_W-1:0];

    logical_sub = sign_a ^ sign_b_eff;
    special     = fp_resolve_special(cls_a, cls_b, logical_sub, equal_mag);

    // For a zero result the AND covers both-zero and exact cancellation (signs differ -> 0).
    case (special)
      FP_NAN:  result_sign = 1'b0;
      FP_INF:  result_sign = cls_a.inf ? sign_a : sign_b_eff;
      FP_ZERO: result_sign = sign_a & sign_b_eff;
      default: result_sign = swap ? sign_b_eff : sign_a;
    endcase
  end

endmodule

// File: rtl/fp_add_align_stage.sv
// rtl/fp_add_align_stage.sv - registered FP add/sub align stage with valid/ready and rollback squash
// Optional: FP_ADD_DENORM_FLUSH_EN (see fp_add_align_lane).
module fp_add_align_stage
  import fp_add_align_stage_pkg::*;
#(
  parameter  int LANES     = 16,
  parameter  int EXP_WIDTH = 8,
  parameter  int SIG_WIDTH = 23,
  parameter  int TID_WIDTH = 2,
  localparam int SHIFT_W   = $clog2(SIG_WIDTH + 4),
  localparam int OP_W      = 1 + EXP_WIDTH + SIG_WIDTH,
  localparam int MAN_W     = SIG_WIDTH + 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         rollback_en,
  input  logic [TID_WIDTH-1:0]         rollback_tid,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [TID_WIDTH-1:0]         in_tid,
  input  logic                         in_subtract,
  input  logic [LANES-1:0]             in_mask,
  input  logic [LANES*OP_W-1:0]        in_op_a,
  input  logic [LANES*OP_W-1:0]        in_op_b,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [TID_WIDTH-1:0]         out_tid,
  output logic [LANES-1:0]             out_mask,
  output logic [LANES*MAN_W-1:0]       out_sig_large,
  output logic [LANES*MAN_W-1:0]       out_sig_small,
  output logic [LANES*SHIFT_W-1:0]     out_shift,
  output logic [LANES*EXP_WIDTH-1:0]   out_exponent,
  output logic [LANES-1:0]             out_logical_sub,
  output logic [LANES-1:0]             out_result_sign,
  output logic [LANES*2-1:0]           out_special
);

  logic [LANES*MAN_W-1:0]     nxt_sig_large, nxt_sig_small;
  logic [LANES*SHIFT_W-1:0]   nxt_shift;
  logic [LANES*EXP_WIDTH-1:0] nxt_exponent;
  logic [LANES-1:0]           nxt_logical_sub, nxt_result_sign;
  logic [LANES*2-1:0]         nxt_special;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    fp_special_t lane_special;

    fp_add_align_lane #(
      .EXP_WIDTH (EXP_WIDTH),
      .SIG_WIDTH (SIG_WIDTH)
    ) u_lane (
      .op_a        (in_op_a[l*OP_W +: OP_W]),
      .op_b        (in_op_b[l*OP_W +: OP_W]),
      .subtract    (in_subtract),
      .sig_large   (nxt_sig_large[l*MAN_W +: MAN_W]),
      .sig_small   (nxt_sig_small[l*MAN_W +: MAN_W]),
      .shift       (nxt_shift[l*SHIFT_W +: SHIFT_W]),
      .exponent    (nxt_exponent[l*EXP_WIDTH +: EXP_WIDTH]),
      .logical_sub (nxt_logical_sub[l]),
      .result_sign (nxt_result_sign[l]),
      .special     (lane_special)
    );

    assign nxt_special[l*2 +: 2] = lane_special;
  end

  logic in_squash, held_squash, load;

  assign in_ready    = !out_valid || out_ready;
  assign in_squash   = rollback_en && (in_tid == rollback_tid);
  assign held_squash = rollback_en && out_valid && (out_tid == rollback_tid);
  assign load        = in_valid && in_ready && !in_squash;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid       <= 1'b0;
      out_tid         <= '0;
      out_mask        <= '0;
      out_sig_large   <= '0;
      out_sig_small   <= '0;
      out_shift       <= '0;
      out_exponent    <= '0;
      out_logical_sub <= '0;
      out_result_sign <= '0;
      out_special     <= '0;
    end else if (load) begin
      out_valid       <= 1'b1;
      out_tid         <= in_tid;
      out_mask        <= in_mask;
      out_sig_large   <= nxt_sig_large;
      out_sig_small   <= nxt_sig_small;
      out_shift       <= nxt_shift;
      out_exponent    <= nxt_exponent;
      out_logical_sub <= nxt_logical_sub;
      out_result_sign <= nxt_result_sign;
      out_special     <= nxt_special;
    end else if (out_ready || held_squash) begin
      // Data is left as-is; only the valid flag retires or squashes the beat.
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fp_add_align_stage.sv
// tb/tb_fp_add_align_stage.sv - self-checking bench for fp_add_align_stage (FP32, 16 lanes)
module tb_fp_add_align_stage;

  localparam int LANES = 16;
  localparam int EW    = 8;
  localparam int SW    = 23;
  localparam int TW    = 2;
  localparam int SHW   = 5;
  localparam int OPW   = 32;
  localparam int SIGW  = 24;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    rollback_en;
  logic [TW-1:0]           rollback_tid;
  logic                    in_valid;
  logic                    in_ready;
  logic [TW-1:0]           in_tid;
  logic                    in_subtract;
  logic [LANES-1:0]        in_mask;
  logic [LANES*OPW-1:0]    in_op_a, in_op_b;
  logic                    out_valid;
  logic                    out_ready;
  logic [TW-1:0]           out_tid;
  logic [LANES-1:0]        out_mask;
  logic [LANES*SIGW-1:0]   out_sig_large, out_sig_small;
  logic [LANES*SHW-1:0]    out_shift;
  logic [LANES*EW-1:0]     out_exponent;
  logic [LANES-1:0]        out_logical_sub, out_result_sign;
  logic [LANES*2-1:0]      out_special;

  fp_add_align_stage #(
    .LANES(LANES), .EXP_WIDTH(EW), .SIG_WIDTH(SW), .TID_WIDTH(TW)
  ) dut (
    .clk(clk), .reset(reset), .rollback_en(rollback_en), .rollback_tid(rollback_tid),
    .in_valid(in_valid), .in_ready(in_ready), .in_tid(in_tid), .in_subtract(in_subtract),
    .in_mask(in_mask), .in_op_a(in_op_a), .in_op_b(in_op_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_tid(out_tid), .out_mask(out_mask),
    .out_sig_large(out_sig_large), .out_sig_small(out_sig_small), .out_shift(out_shift),
    .out_exponent(out_exponent), .out_logical_sub(out_logical_sub),
    .out_result_sign(out_result_sign), .out_special(out_special)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [SIGW-1:0] sig_large;
    logic [SIGW-1:0] sig_small;
    logic [SHW-1:0]  shift;
    logic [EW-1:0]   exponent;
    logic            lsub;
    logic            rsign;
    logic [1:0]      special;
  } lane_exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    lane_exp_t   e;
  } vec_t;

  typedef struct {
    logic [TW-1:0]         tid;
    logic [LANES-1:0]      mask;
    logic [LANES*SIGW-1:0] sig_large, sig_small;
    logic [LANES*SHW-1:0]  shift;
    logic [LANES*EW-1:0]   exponent;
    logic [LANES-1:0]      lsub, rsign;
    logic [LANES*2-1:0]    special;
  } beat_t;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] ra [LANES];
  logic [31:0] rb [LANES];
  lane_exp_t   le [LANES];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic lane_exp_t mk(logic [23:0] sl, logic [23:0] ss, int sh, int ex,
                                   logic ls, logic rs, logic [1:0] sp);
    lane_exp_t r;
    r.sig_large = sl; r.sig_small = ss; r.shift = SHW'(sh); r.exponent = EW'(ex);
    r.lsub = ls; r.rsign = rs; r.special = sp;
    return r;
  endfunction

  function automatic vec_t mkv(logic [31:0] a, logic [31:0] b, logic sub, lane_exp_t e);
    vec_t v;
    v.a = a; v.b = b; v.sub = sub; v.e = e;
    return v;
  endfunction

  // Reference: decode to integers, compare magnitudes numerically, apply the special rules.
  function automatic lane_exp_t ref_lane(logic [31:0] a, logic [31:0] b, logic sub);
    lane_exp_t r;
    bit     sa, sb, big_b, nan_a, nan_b, inf_a, inf_b, z_a, z_b;
    int     ea, eb, el, es, sh;
    longint ma, mb, ml, ms, mag_a, mag_b;
    sa = a[31]; sb = b[31] ^ sub;
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    ma = longint'(a[22:0]); mb = longint'(b[22:0]);
`ifdef FP_ADD_DENORM_FLUSH_EN
    if (ea == 0) ma = 0;
    if (eb == 0) mb = 0;
`endif
    mag_a = longint'(ea) * 8388608 + ma;
    mag_b = longint'(eb) * 8388608 + mb;
    big_b = mag_b > mag_a;
    el = big_b ? eb : ea; es = big_b ? ea : eb;
    ml = big_b ? mb : ma; ms = big_b ? ma : mb;
    r.sig_large = 24'((el != 0 ? 8388608 : 0) + ml);
    r.sig_small = 24'((es != 0 ? 8388608 : 0) + ms);
    r.exponent  = 8'(el);
`ifdef FP_ADD_DENORM_FLUSH_EN
    sh = el - es;
`else
    sh = el - ((es == 0) ? 1 : es);
`endif
    if (sh < 0) sh = 0;
    if (sh > 26) sh = 26;
    r.shift = 5'(sh);
    r.lsub  = sa ^ sb;
    nan_a = (ea == 255) && (ma != 0); nan_b = (eb == 255) && (mb != 0);
    inf_a = (ea == 255) && (ma == 0); inf_b = (eb == 255) && (mb == 0);
    z_a = (ea == 0) && (ma == 0);     z_b = (eb == 0) && (mb == 0);
    if (nan_a || nan_b || (inf_a && inf_b && r.lsub)) begin
      r.special = 2'b11; r.rsign = 1'b0;
    end else if (inf_a || inf_b) begin
      r.special = 2'b10; r.rsign = inf_a ? sa : sb;
    end else if (z_a && z_b) begin
      r.special = 2'b01; r.rsign = sa & sb;
    end else if (mag_a == mag_b && r.lsub) begin
      r.special = 2'b01; r.rsign = 1'b0;
    end else begin
      r.special = 2'b00; r.rsign = big_b ? sb : sa;
    end
    return r;
  endfunction

  function automatic beat_t pack_beat(logic [TW-1:0] tid, logic [LANES-1:0] mask);
    beat_t b;
    b.tid = tid; b.mask = mask;
    for (int l = 0; l < LANES; l++) begin
      b.sig_large[l*SIGW +: SIGW] = le[l].sig_large;
      b.sig_small[l*SIGW +: SIGW] = le[l].sig_small;
      b.shift[l*SHW +: SHW]       = le[l].shift;
      b.exponent[l*EW +: EW]      = le[l].exponent;
      b.lsub[l]                   = le[l].lsub;
      b.rsign[l]                  = le[l].rsign;
      b.special[l*2 +: 2]         = le[l].special;
    end
    return b;
  endfunction

  function automatic logic [31:0] rand_op();
    logic s;
    s = 1'($urandom);
    case ($urandom_range(0, 9))
      0: return {s, 31'h0};
      1: return {s, 8'hFF, 23'h0};
      2: return {s, 8'hFF, 23'($urandom) | 23'h1};
      3: return {s, 8'h00, 23'($urandom)};
      default: return $urandom;
    endcase
  endfunction

  task automatic randomize_ops();
    for (int l = 0; l < LANES; l++) begin
      ra[l] = rand_op();
      case ($urandom_range(0, 3))
        0: rb[l] = ra[l];
        1: rb[l] = ra[l] ^ 32'h8000_0000;
        2: rb[l] = {1'($urandom), ra[l][30:23], 23'($urandom)};
        default: rb[l] = rand_op();
      endcase
    end
  endtask

  // Drives ra/rb onto the bus and returns the reference beat for them.
  task automatic drive_ops(input logic [TW-1:0] tid, input logic sub, output beat_t e);
    logic [LANES-1:0] mask;
    mask = LANES'($urandom);
    for (int l = 0; l < LANES; l++) begin
      in_op_a[l*OPW +: OPW] = ra[l];
      in_op_b[l*OPW +: OPW] = rb[l];
      le[l] = ref_lane(ra[l], rb[l], sub);
    end
    in_tid = tid; in_subtract = sub; in_mask = mask;
    e = pack_beat(tid, mask);
  endtask

  task automatic check_beat(input string tag, input beat_t e);
    chk({tag, ".tid"},       512'(out_tid),         512'(e.tid));
    chk({tag, ".mask"},      512'(out_mask),        512'(e.mask));
    chk({tag, ".sig_large"}, 512'(out_sig_large),   512'(e.sig_large));
    chk({tag, ".sig_small"}, 512'(out_sig_small),   512'(e.sig_small));
    chk({tag, ".shift"},     512'(out_shift),       512'(e.shift));
    chk({tag, ".exponent"},  512'(out_exponent),    512'(e.exponent));
    chk({tag, ".lsub"},      512'(out_logical_sub), 512'(e.lsub));
    chk({tag, ".rsign"},     512'(out_result_sign), 512'(e.rsign));
    chk({tag, ".special"},   512'(out_special),     512'(e.special));
  endtask

  vec_t  vecs[$];
  beat_t e_cur, e_held, m_beat;
  logic  m_valid, exp_ready, kill_held, accept;

  initial begin
    reset = 1'b1; rollback_en = 1'b0; rollback_tid = '0; in_valid = 1'b0;
    in_tid = '0; in_subtract = 1'b0; in_mask = '0; in_op_a = '0; in_op_b = '0;
    out_ready = 1'b1;

    vecs.push_back(mkv(32'h4040_0000, 32'h3F80_0000, 1'b0, mk(24'hC00000, 24'h800000, 1, 128, 0, 0, 2'b00)));
    vecs.push_back(mkv(32'h3F80_0000, 32'hC000_0000, 1'b0, mk(24'h800000, 24'h800000, 1, 128, 1, 1, 2'b00)));
    vecs.push_back(mkv(32'h7F00_0000, 32'h0080_0000, 1'b0, mk(24'h800000, 24'h800000, 26, 254, 0, 0, 2'b00)));
    vecs.push_back(mkv(32'h7F80_0000, 32'h7F80_0000, 1'b1, mk(24'h800000, 24'h800000, 0, 255, 1, 0, 2'b11)));
    vecs.push_back(mkv(32'h7FC0_0000, 32'h3F80_0000, 1'b0, mk(24'hC00000, 24'h800000, 26, 255, 0, 0, 2'b11)));
    vecs.push_back(mkv(32'h3F80_0000, 32'h3F80_0000, 1'b1, mk(24'h800000, 24'h800000, 0, 127, 1, 0, 2'b01)));
`ifdef FP_ADD_DENORM_FLUSH_EN
    vecs.push_back(mkv(32'h3F80_0000, 32'h0000_0001, 1'b0, mk(24'h800000, 24'h000000, 26, 127, 0, 0, 2'b00)));
`else
    vecs.push_back(mkv(32'h3F80_0000, 32'h0000_0001, 1'b0, mk(24'h800000, 24'h000001, 26, 127, 0, 0, 2'b00)));
`endif
    vecs.push_back(mkv(32'hFF80_0000, 32'h3F80_0000, 1'b0, mk(24'h800000, 24'h800000, 26, 255, 1, 1, 2'b10)));
    vecs.push_back(mkv(32'h8000_0000, 32'h8000_0000, 1'b0, mk(24'h000000, 24'h000000, 0, 0, 0, 1, 2'b01)));
    vecs.push_back(mkv(32'h3FC0_0000, 32'h3FA0_0000, 1'b1, mk(24'hC00000, 24'hA00000, 0, 127, 1, 0, 2'b00)));

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset.out_valid", 512'(out_valid), 512'(0));
    chk("reset.in_ready", 512'(in_ready), 512'(1));
    chk("reset.sig_large", 512'(out_sig_large), 512'(0));
    chk("reset.shift", 512'(out_shift), 512'(0));
    chk("reset.special", 512'(out_special), 512'(0));
    chk("reset.tid", 512'(out_tid), 512'(0));
    reset = 1'b0;

    // Directed vectors, broadcast to every lane
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      for (int l = 0; l < LANES; l++) begin
        in_op_a[l*OPW +: OPW] = vecs[i].a;
        in_op_b[l*OPW +: OPW] = vecs[i].b;
        le[l] = vecs[i].e;
      end
      in_valid = 1'b1; in_tid = TW'(i); in_subtract = vecs[i].sub; in_mask = LANES'($urandom);
      e_cur = pack_beat(TW'(i), in_mask);
      @(posedge clk); #1;
      chk($sformatf("vec%0d.out_valid", i), 512'(out_valid), 512'(1));
      check_beat($sformatf("vec%0d", i), e_cur);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("drain.out_valid", 512'(out_valid), 512'(0));

    // Stall: held beat stays stable, in_ready low; then roll back its thread
    @(negedge clk);
    randomize_ops(); drive_ops(2'd1, 1'($urandom), e_held);
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    chk("stall.load_valid", 512'(out_valid), 512'(1));
    check_beat("stall.load", e_held);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      randomize_ops(); drive_ops(2'd2, 1'($urandom), e_cur);
      #1 chk($sformatf("stall%0d.in_ready", c), 512'(in_ready), 512'(0));
      @(posedge clk); #1;
      chk($sformatf("stall%0d.out_valid", c), 512'(out_valid), 512'(1));
      check_beat($sformatf("stall%0d", c), e_held);
    end
    @(negedge clk);
    rollback_en = 1'b1; rollback_tid = 2'd1;
    @(posedge clk); #1;
    chk("rb_held.out_valid", 512'(out_valid), 512'(0));
    chk("rb_held.in_ready", 512'(in_ready), 512'(1));

    // Incoming beat of the rolled-back thread is not loaded
    @(negedge clk);
    out_ready = 1'b1; rollback_tid = 2'd3;
    randomize_ops(); drive_ops(2'd3, 1'b0, e_cur);
    @(posedge clk); #1;
    chk("rb_in.out_valid", 512'(out_valid), 512'(0));

    // Held beat rolled back while an unrelated beat loads
    @(negedge clk);
    rollback_en = 1'b0;
    randomize_ops(); drive_ops(2'd1, 1'b0, e_held);
    @(posedge clk); #1;
    @(negedge clk);
    rollback_en = 1'b1; rollback_tid = 2'd1;
    randomize_ops(); drive_ops(2'd2, 1'b1, e_cur);
    @(posedge clk); #1;
    chk("rb_swap.out_valid", 512'(out_valid), 512'(1));
    check_beat("rb_swap", e_cur);

    // Asynchronous reset mid-operation
    @(negedge clk);
    rollback_en = 1'b0; out_ready = 1'b0;
    randomize_ops(); drive_ops(2'd0, 1'b0, e_cur);
    @(posedge clk); #1;
    #2 reset = 1'b1;
    #1;
    chk("async_reset.out_valid", 512'(out_valid), 512'(0));
    chk("async_reset.sig_large", 512'(out_sig_large), 512'(0));
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;

    // Randomized traffic against the one-slot reference
    m_valid = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      randomize_ops(); drive_ops(TW'($urandom), 1'($urandom), e_cur);
      in_valid     = ($urandom_range(0, 3) != 0);
      out_ready    = ($urandom_range(0, 2) != 0);
      rollback_en  = ($urandom_range(0, 5) == 0);
      rollback_tid = TW'($urandom);
      #1;
      exp_ready = !m_valid || out_ready;
      chk($sformatf("rnd%0d.in_ready", n), 512'(in_ready), 512'(exp_ready));
      kill_held = rollback_en && m_valid && (m_beat.tid == rollback_tid);
      accept    = in_valid && exp_ready && !(rollback_en && in_tid == rollback_tid);
      if (accept) begin
        m_valid = 1'b1; m_beat = e_cur;
      end else if (out_ready || kill_held) begin
        m_valid = 1'b0;
      end
      @(posedge clk); #1;
      chk($sformatf("rnd%0d.out_valid", n), 512'(out_valid), 512'(m_valid));
      if (m_valid) check_beat($sformatf("rnd%0d", n), m_beat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
